hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MC_LAT, default 4, range 2..15: total ID-stage occupancy in cycles of a multi-cycle (mult/div) instruction.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-003 clkHC  in  1  pipeline clock; all state updates on rising edge.
REQ-004 rstHC_n  in  1  asynchronous active-low reset.
REQ-005 IDEX_MemRead  in  1  the instruction in ID/EX is a load.
REQ-006 IDEX_Rt  in  5  load destination register held in ID/EX.
REQ-007 IFID_Rs, IFID_Rt  in  5 each  source registers of the instruction in IF/ID.
REQ-008 IFID_UsesRt  in  1  the IF/ID instruction reads Rt.
REQ-009 IFID_Jump  in  1  the IF/ID instruction is an unconditional jump.
REQ-010 MC_Start  in  1  the IF/ID instruction is a multi-cycle op.
REQ-011 EX_BrTaken  in  1  the branch in EX resolved taken.
REQ-012 PCWrite, IFIDWrite  out  1 each  PC and IF/ID load enables.
REQ-013 IFIDFlush  out  1  clear IF/ID to NOP.
REQ-014 IDEXBubble  out  1  zero the WB/M/EX control fields entering ID/EX.
REQ-015 Busy  out  1  high while state is MCWAIT.
REQ-016 StallCnt, FlushCnt  out  16 each  saturating performance counters.

Function
REQ-017 States SHALL be RUN and MCWAIT; a 4-bit down-counter cnt is held in registers.
REQ-018 Outputs SHALL be combinational from state, cnt and inputs (zero-cycle latency); defaults are PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
REQ-019 Load-use hazard SHALL be IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==IFID_Rs || (IFID_UsesRt && IDEX_Rt==IFID_Rt)).
REQ-020 RUN priority, highest first: EX_BrTaken, load-use, MC_Start, IFID_Jump.
REQ-021 EX_BrTaken (any state): IFIDFlush=1, IDEXBubble=1, PCWrite=1; next state RUN; cnt=0.
REQ-022 Load-use in RUN: PCWrite=0, IFIDWrite=0, IDEXBubble=1 for that cycle only; state stays RUN.
REQ-023 MC_Start in RUN: stall as in REQ-022; cnt<=MC_LAT-2; next state MCWAIT.
REQ-024 MCWAIT with cnt!=0: stall as in REQ-022; cnt decrements.
REQ-025 MCWAIT with cnt==0: default outputs (release); MC_Start and load-use ignored; next state RUN.
REQ-026 Hence a multi-cycle op SHALL cause exactly MC_LAT-1 stall cycles, followed by one release cycle.
REQ-027 IFID_Jump in RUN (no higher event): IFIDFlush=1, PCWrite=1; IDEXBubble=0.
REQ-028 If MC_Start and IFID_Jump are both high, MC_Start wins.
REQ-029 StallCnt SHALL increment in every cycle with PCWrite==0, saturating at 0xFFFF.
REQ-030 FlushCnt SHALL increment in every cycle with IFIDFlush==1, saturating at 0xFFFF.

Reset
REQ-031 While rstHC_n is low: state=RUN, cnt=0, StallCnt=0, FlushCnt=0, Busy=0.
REQ-032 While rstHC_n is low, outputs SHALL be forced to PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1.
REQ-033 Reset asserted in MCWAIT SHALL abort the op immediately, with no release cycle.
REQ-034 Counters SHALL not count during reset.

Structure
REQ-035 Package hazard_pkg SHALL hold the state enum, MC_LAT default and the counter width (16).
REQ-036 Saturating counter SHALL be a sub-module sat_cnt (enable, async clear), instantiated twice.

Verification
REQ-037 IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 for one cycle -> one cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1; StallCnt 0->1.
REQ-038 Same stimulus with IDEX_Rt=0, or IFID_Rt=8 with IFID_UsesRt=0 -> no stall; StallCnt unchanged.
REQ-039 MC_Start at cycle 0, MC_LAT=4 -> PCWrite=0 in cycles 0-2, Busy=1 in cycles 1-3, release in cycle 3, RUN in cycle 4; StallCnt=3.
REQ-040 EX_BrTaken in cycle 2 of REQ-039 -> IFIDFlush=1, IDEXBubble=1, PCWrite=1, RUN in cycle 3; FlushCnt=1.
REQ-041 EX_BrTaken together with load-use and IFID_Jump -> flush only, no stall; StallCnt unchanged; FlushCnt+1.
REQ-042 rstHC_n low mid-MCWAIT -> immediate forced outputs, Busy=0, counters 0; 70000 load-use cycles -> StallCnt holds 0xFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and sizes for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_MCWAIT = 1'b1
   } state_e;

   localparam int unsigned MC_LAT_DEF = 4;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned MCC_W      = 4;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with enable; the async reset doubles as its clear.
module sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle op stalls,
// branch/jump flushes, plus stall and flush performance counters.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MC_LAT = MC_LAT_DEF
) (
   input  logic             clkHC,
   input  logic             rstHC_n,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_Rt,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             IFID_UsesRt,
   input  logic             IFID_Jump,
   input  logic             MC_Start,
   input  logic             EX_BrTaken,
   output logic             PCWrite,
   output logic             IFIDWrite,
   output logic             IFIDFlush,
   output logic             IDEXBubble,
   output logic             Busy,
   output logic [CNT_W-1:0] StallCnt,
   output logic [CNT_W-1:0] FlushCnt
);

   state_e           state_q, state_d;
   logic [MCC_W-1:0] cnt_q, cnt_d;
   logic             load_use_c;
   logic             pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;

   assign load_use_c = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                       ((IDEX_Rt == IFID_Rs) || (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));

   // Next state and zero-latency control outputs; a taken branch overrides everything.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_write_c    = 1'b1;
      ifid_write_c  = 1'b1;
      ifid_flush_c  = 1'b0;
      idex_bubble_c = 1'b0;

      if (EX_BrTaken) begin
         ifid_flush_c  = 1'b1;
         idex_bubble_c = 1'b1;
         state_d       = ST_RUN;
         cnt_d         = '0;
      end else if (state_q == ST_MCWAIT) begin
         if (cnt_q != '0) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
            cnt_d         = cnt_q - MCC_W'(1);
         end else begin
            state_d = ST_RUN;
         end
      end else if (load_use_c) begin
         pc_write_c    = 1'b0;
         ifid_write_c  = 1'b0;
         idex_bubble_c = 1'b1;
      end else if (MC_Start) begin
         pc_write_c    = 1'b0;
         ifid_write_c  = 1'b0;
         idex_bubble_c = 1'b1;
         cnt_d         = MCC_W'(MC_LAT - 2);
         state_d       = ST_MCWAIT;
      end else if (IFID_Jump) begin
         ifid_flush_c = 1'b1;
      end

      // Hold the pipeline frozen and flushed while in reset.
      if (!rstHC_n) begin
         pc_write_c    = 1'b0;
         ifid_write_c  = 1'b0;
         ifid_flush_c  = 1'b1;
         idex_bubble_c = 1'b1;
      end
   end

   always_ff @(posedge clkHC or negedge rstHC_n) begin
      if (!rstHC_n) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign PCWrite    = pc_write_c;
   assign IFIDWrite  = ifid_write_c;
   assign IFIDFlush  = ifid_flush_c;
   assign IDEXBubble = idex_bubble_c;
   assign Busy       = (state_q == ST_MCWAIT);

   sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk_i  (clkHC),
      .rst_ni (rstHC_n),
      .en_i   (~pc_write_c),
      .cnt_o  (StallCnt)
   );

   sat_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk_i  (clkHC),
      .rst_ni (rstHC_n),
      .en_i   (ifid_flush_c),
      .cnt_o  (FlushCnt)
   );

endmodule
